txn_arbiter: RTL

- Two-port arbiter that lets the path fabric controller (port 0) and the host-side map/direction DMA (port 1) share one memory transaction port.
- Both requesters use the single-cycle-pulse protocol: `req` is high for 1 cycle with `addr`/`wr`/`wdata` valid, then the requester waits for a 1-cycle `rdy` carrying `rdata`.
- The arbiter captures each pulse, issues requests to memory one at a time in round-robin order, and routes each response back to its owner.

---
 rtl/txn_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/txn_arbiter.sv
// Two-port round-robin arbiter sharing one pulse-protocol memory port.
// Optional TXN_TIMEOUT_EN: abort a stalled memory transaction after TIMEOUT_CYC cycles.
package txn_arbiter_pkg;
  typedef struct packed {
    logic        pend;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } slot_t;
endpackage

module txn_slot
  import txn_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        clr,
  output slot_t       slot,
  output logic        overrun
);
  // A request in the completion cycle refills the slot rather than overrunning it.
  assign overrun = req & slot.pend & ~clr;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                         slot      <= '0;
    else if (req && (!slot.pend || clr)) slot      <= '{pend: 1'b1, wr: wr, addr: addr, wdata: wdata};
    else if (clr)                        slot.pend <= 1'b0;
  end
endmodule

module txn_arbiter
  import txn_arbiter_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [31:0] ERR_RDATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        p0_req,
  input  logic        p0_wr,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_rdy,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_wr,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_rdy,
  output logic [31:0] p1_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rdy,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  input  logic        err_clr,
  output logic        err_overrun,
  output logic        err_timeout
);
  typedef enum logic {IDLE, WAIT} state_t;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_bad_cfg
    $error("txn_arbiter: TIMEOUT_CYC out of range");
  end

  state_t            state_q, state_d;
  slot_t             slot [2];
  logic [1:0]        req_v, wr_v, clr_v, ovr_v, rdy_v;
  logic [1:0][31:0]  addr_v, wdata_v, rdata_q;
  logic              owner, last_grant, win, done, tmo;
  logic [31:0]       rdata_ret;

  assign req_v   = {p1_req, p0_req};
  assign wr_v    = {p1_wr, p0_wr};
  assign addr_v  = {p1_addr, p0_addr};
  assign wdata_v = {p1_wdata, p0_wdata};

  for (genvar i = 0; i < 2; i++) begin : g_slot
    txn_slot u_slot (
      .clk    (clk),
      .arst_n (arst_n),
      .req    (req_v[i]),
      .wr     (wr_v[i]),
      .addr   (addr_v[i]),
      .wdata  (wdata_v[i]),
      .clr    (clr_v[i]),
      .slot   (slot[i]),
      .overrun(ovr_v[i])
    );
  end

  // On a tie the port that did not win last time goes next.
  assign win = (slot[0].pend && (!slot[1].pend || last_grant)) ? 1'b0 : 1'b1;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (slot[0].pend || slot[1].pend) state_d = WAIT;
      WAIT:    if (mem_rdy || tmo)               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == IDLE) && (slot[0].pend || slot[1].pend);
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      mem_wr    = slot[win].wr;
      mem_addr  = slot[win].addr;
      mem_wdata = slot[win].wdata;
    end
    done      = (state_q == WAIT) && (mem_rdy || tmo);
    rdy_v     = '0;
    if (done) rdy_v[owner] = 1'b1;
    clr_v     = rdy_v;
    rdata_ret = mem_rdy ? mem_rdata : ERR_RDATA;
  end

  assign p0_rdy   = rdy_v[0];
  assign p1_rdy   = rdy_v[1];
  assign p0_rdata = rdy_v[0] ? rdata_ret : rdata_q[0];
  assign p1_rdata = rdy_v[1] ? rdata_ret : rdata_q[1];
  assign busy     = (state_q == WAIT) | slot[0].pend | slot[1].pend;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      rdata_q     <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (mem_req) begin
        owner      <= win;
        last_grant <= win;
      end
      if (done) rdata_q[owner] <= rdata_ret;
      err_overrun <= (|ovr_v) | (err_overrun & ~err_clr);
    end
  end

`ifdef TXN_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign tmo = (state_q == WAIT) && (tmo_cnt == 16'(TIMEOUT_CYC - 1));

  // Held at zero outside WAIT, so it starts from zero on every entry.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      tmo_cnt     <= (state_q == WAIT && state_d == WAIT) ? tmo_cnt + 16'd1 : 16'd0;
      err_timeout <= (tmo & ~mem_rdy) | (err_timeout & ~err_clr);
    end
  end
`else
  assign tmo         = 1'b0;
  assign err_timeout = 1'b0;
`endif
endmodule
